// File: rtl/spsram_fifo_ctrl.sv
// FIFO controller driving a single-port synchronous SRAM, with a 2-entry
// output buffer that hides the SRAM's 1-cycle read latency.
module spsram_fifo_ctrl #(
    parameter int BW_DATA = 32,
    parameter int BW_ADDR = 4
) (
    input  logic               i_clk,
    input  logic               i_rstn,
    input  logic               i_push_valid,
    output logic               o_push_ready,
    input  logic [BW_DATA-1:0] i_push_data,
    output logic               o_pop_valid,
    input  logic               i_pop_ready,
    output logic [BW_DATA-1:0] o_pop_data,
    output logic [BW_ADDR+1:0] o_count,
    output logic               o_full,
    output logic               o_empty,
    output logic [BW_DATA-1:0] o_sram_data,
    output logic [BW_ADDR-1:0] o_sram_addr,
    output logic               o_sram_wen,
    output logic               o_sram_cen,
    output logic               o_sram_oen,
    input  logic [BW_DATA-1:0] i_sram_data
);

    localparam int DEPTH = 2 ** BW_ADDR;

    logic [BW_ADDR-1:0] wr_ptr;
    logic [BW_ADDR-1:0] rd_ptr;
    logic [BW_ADDR-1:0] addr_q;
    logic [BW_DATA-1:0] data_q;
    logic [BW_ADDR:0]   mem_cnt;
    logic               rd_pend;
    logic [1:0]         ob_cnt;
    logic [BW_DATA-1:0] ob [2];

    logic       pop_dec;
    logic       rd_go;
    logic       push_go;
    logic [2:0] occ;
    logic [2:0] lim;

    // Status is a function of registered state only.
    assign o_full      = (mem_cnt == (BW_ADDR+1)'(DEPTH));
    assign o_count     = (BW_ADDR+2)'(mem_cnt) + (BW_ADDR+2)'(rd_pend) + (BW_ADDR+2)'(ob_cnt);
    assign o_empty     = (o_count == '0);
    assign o_pop_valid = (ob_cnt != 2'd0);
    assign o_pop_data  = ob[0];

    // A read may be issued only if its data is guaranteed a buffer slot
    // when it returns; a pop this cycle frees one slot.
    always_comb begin
        pop_dec      = o_pop_valid & i_pop_ready;
        occ          = {1'b0, ob_cnt} + {2'b00, rd_pend};
        lim          = 3'd2 + {2'b00, pop_dec};
        rd_go        = (mem_cnt != '0) && (occ < lim);
        o_push_ready = i_rstn && !o_full && !rd_go;
        push_go      = i_push_valid && o_push_ready;
    end

    always_comb begin
        o_sram_cen  = rd_go | push_go;
        o_sram_wen  = push_go;
        o_sram_oen  = rd_go;
        o_sram_addr = addr_q;
        o_sram_data = data_q;
        if (rd_go) begin
            o_sram_addr = rd_ptr;
        end else if (push_go) begin
            o_sram_addr = wr_ptr;
            o_sram_data = i_push_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            mem_cnt <= '0;
            rd_pend <= 1'b0;
        end else begin
            rd_pend <= rd_go;
            if (o_sram_cen) begin
                addr_q <= o_sram_addr;
            end
            if (push_go) begin
                data_q <= i_push_data;
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_go) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_go, rd_go})
                2'b10:   mem_cnt <= mem_cnt + 1'b1;
                2'b01:   mem_cnt <= mem_cnt - 1'b1;
                default: mem_cnt <= mem_cnt;
            endcase
        end
    end

    // Output buffer: ob[0] is the head; returning read data lands at the tail.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            ob_cnt <= 2'd0;
            ob[0]  <= '0;
            ob[1]  <= '0;
        end else if (rd_pend && pop_dec) begin
            if (ob_cnt == 2'd2) begin
                ob[0] <= ob[1];
                ob[1] <= i_sram_data;
            end else begin
                ob[0] <= i_sram_data;
            end
        end else if (pop_dec) begin
            ob[0]  <= ob[1];
            ob_cnt <= ob_cnt - 2'd1;
        end else if (rd_pend) begin
            if (ob_cnt == 2'd0) begin
                ob[0] <= i_sram_data;
            end else begin
                ob[1] <= i_sram_data;
            end
            ob_cnt <= ob_cnt + 2'd1;
        end
    end

endmodule
